// File: rtl/ldpc_ber_tester_pkg.sv
// Shared constants for the LDPC BER tester datapath.
// PRBS-31 polynomial x^31+x^28+1 and zero-seed substitution.
package ldpc_ber_tester_pkg;

  localparam int DATA_W = 128;
  localparam int PRBS_ORDER = 31;
  localparam int PRBS_TAP = 28;
  localparam logic [30:0] PRBS_SEED_ZERO_SUBST = 31'h7FFFFFFF;

  function automatic logic [30:0] prbs_seed_fix(
    input logic [30:0] seed
  );
    return (seed == '0) ? PRBS_SEED_ZERO_SUBST : seed;
  endfunction

endpackage

// File: rtl/ldpc_ber_tester_prbs128.sv
// PRBS-31 Fibonacci LFSR producing 128 expected bits per beat.
// Bit 0 of expected is the first generated bit.
module ldpc_ber_tester_prbs128
  import ldpc_ber_tester_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [PRBS_ORDER-1:0] seed,
  input  logic                  advance,
  input  logic                  load,
  output logic [DATA_W-1:0]     expected
);

  logic [PRBS_ORDER-1:0] state;
  logic [PRBS_ORDER-1:0] walk;
  logic [PRBS_ORDER-1:0] state_nxt;
  logic                  fb;

  always_comb begin
    walk     = state;
    fb       = 1'b0;
    expected = '0;
    for (int k = 0; k < DATA_W; k++) begin
      fb          = walk[PRBS_ORDER-1] ^ walk[PRBS_TAP-1];
      expected[k] = fb;
      walk        = {walk[PRBS_ORDER-2:0], fb};
    end
    state_nxt = walk;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= prbs_seed_fix(seed);
    end else if (load) begin
      state <= prbs_seed_fix(seed);
    end else if (advance) begin
      state <= state_nxt;
    end
  end

endmodule

// File: rtl/ldpc_ber_tester_dout_compare.sv
// Decoded-data vs PRBS compare stage; emits error pattern + last-beat mask.
// Optional LDPC_BER_TESTER_FRAME_ERR_CNT_EN adds a frame error counter.
module ldpc_ber_tester_dout_compare #(
  parameter int DATA_W = 128,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [LEN_W-1:0]  block_len_bits,
  input  logic [30:0]       prbs_seed,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [DATA_W-1:0] last_mask,
  output logic              length_error,
  output logic              active
`ifdef LDPC_BER_TESTER_FRAME_ERR_CNT_EN
  ,
  output logic [63:0]       frame_errors
`endif
);

  import ldpc_ber_tester_pkg::*;

  logic              acc;
  logic [DATA_W-1:0] expected;
  logic [DATA_W-1:0] mask_nxt;
  logic [LEN_W-1:0]  beat_cnt;
  logic [LEN_W-1:0]  last_idx;
  logic [6:0]        rem;
  logic              at_last;

  assign s_axis_tready = !m_axis_tvalid | m_axis_tready;
  assign acc           = s_axis_tvalid & s_axis_tready;
  assign active        = (beat_cnt != '0) | m_axis_tvalid;

  // Index of the final beat: ceil(len/128)-1, with len=0 as one beat.
  assign last_idx = (block_len_bits == '0) ? '0
                  : (block_len_bits - LEN_W'(1)) >> 7;
  assign at_last  = (beat_cnt == last_idx);

  assign rem      = block_len_bits[6:0];
  assign mask_nxt = (rem == '0) ? '1
                  : ((DATA_W'(1) << rem) - DATA_W'(1));

  ldpc_ber_tester_prbs128 u_prbs (
    .clk      (clk),
    .resetn   (resetn),
    .seed     (prbs_seed),
    .advance  (acc & !s_axis_tlast),
    .load     (acc & s_axis_tlast),
    .expected (expected)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      beat_cnt      <= '0;
      length_error  <= 1'b0;
      last_mask     <= '1;
    end else begin
      if (acc) begin
        m_axis_tdata  <= s_axis_tdata ^ expected;
        m_axis_tlast  <= s_axis_tlast;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (acc) begin
        if (s_axis_tlast) begin
          beat_cnt <= '0;
        end else begin
          beat_cnt <= beat_cnt + LEN_W'(1);
        end
        if (s_axis_tlast != at_last) begin
          length_error <= 1'b1;
        end
      end
      if (!active) begin
        last_mask <= mask_nxt;
      end
    end
  end

`ifdef LDPC_BER_TESTER_FRAME_ERR_CNT_EN
  logic out_hs;
  logic frame_err;
  logic masked_any;
  logic frame_hit;

  assign out_hs     = m_axis_tvalid & m_axis_tready;
  assign masked_any = |(m_axis_tdata & (m_axis_tlast ? last_mask : '1));
  assign frame_hit  = frame_err | masked_any;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      frame_errors <= '0;
      frame_err    <= 1'b0;
    end else if (out_hs) begin
      if (m_axis_tlast) begin
        frame_err <= 1'b0;
        if (frame_hit && (frame_errors != '1)) begin
          frame_errors <= frame_errors + 64'd1;
        end
      end else begin
        frame_err <= frame_hit;
      end
    end
  end
`endif

endmodule
